btn_cmd_encoder: RTL

Front-end conditioner that turns four raw, bouncing push-buttons into the clean one-hot command word consumed by the LED pattern FSM. Encodings: 4'b0001 = reset pattern, 4'b0010 = shift left, 4'b0100 = shift right, 4'b1000 = pause. Each button is synchronised and debounced on its own path. A press-to-command encoder emits exactly one single-cycle command per physical press, then locks out further commands until every button is released.

---
 rtl/btn_cmd_encoder.sv | 110 +++++++++++
 1 files changed

// File: rtl/btn_cmd_encoder.sv
// Four-button front end: 2-flop sync, per-bit debounce, rising-edge press detect and a
// one-shot priority encoder that locks out further commands until all buttons are released.
module btn_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int CNT_W           = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic [1:0] last_cmd,
    output logic       busy
);

    localparam logic [0:0]       S_IDLE  = 1'b0;
    localparam logic [0:0]       S_HELD  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]            s1_q, s2_q;
    logic [3:0]            stable_q, stable_d;
    logic [3:0]            stable_dly_q;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]            state_q, state_d;
    logic [3:0]            cmd_q, cmd_d;
    logic                  vld_q, vld_d;
    logic [1:0]            last_q, last_d;
    logic [3:0]            rise;
    logic [1:0]            sel_idx;

    // Any cycle where the synchronised level agrees with the accepted level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign rise = stable_q & ~stable_dly_q;

    // Lowest index wins, so the reset-pattern button has top priority.
    always_comb begin
        sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rise[i]) begin
                sel_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = 4'b0000;
        vld_d   = 1'b0;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (rise != 4'b0000) begin
                    cmd_d   = 4'b0001 << sel_idx;
                    vld_d   = 1'b1;
                    last_d  = sel_idx;
                    state_d = S_HELD;
                end
            end
            default: begin
                if (stable_q == 4'b0000) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '0;
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            vld_q        <= 1'b0;
            last_q       <= '0;
        end else begin
            s1_q         <= btn_raw;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            vld_q        <= vld_d;
            last_q       <= last_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = vld_q;
    assign last_cmd  = last_q;
    assign busy      = (state_q == S_HELD);

endmodule
